// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor datapath widths
package proc_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write reservation vector
module reg_scoreboard #(
    parameter int ADDR_W   = proc_pkg::ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    output logic [NUM_REGS-1:0] pending_next
);

    logic [NUM_REGS-1:0] pending;

    // Clear on write-back, then set on issue so a same-cycle reservation survives; R0 never pends
    always_comb begin
        pending_next = pending;
        if (wr_en) begin
            pending_next[wr_addr] = 1'b0;
        end
        if (issue_en) begin
            pending_next[issue_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Pending vector register
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/reg_file_8x16.sv
// rtl/reg_file_8x16.sv - 2-read 1-write register file with write bypass and busy scoreboard
module reg_file_8x16 #(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic              rd_valid,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;
    logic [NUM_REGS-1:0] pending_next;

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue_en     (issue_en),
        .issue_addr   (issue_addr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .pending_next (pending_next)
    );

    // Register storage; R0 is hardwired to zero so its slot is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read mux with same-cycle write bypass; R0 forced to zero last so bypass cannot override it
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end
    end

    // Operand output registers; they hold their last result while no read is requested
    always_ff @(posedge clk) begin
        if (rst) begin
            val1     <= '0;
            val2     <= '0;
            rd_valid <= 1'b0;
            busy_a   <= 1'b0;
            busy_b   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                val1   <= rd_data_a;
                val2   <= rd_data_b;
                busy_a <= pending_next[rd_addr_a];
                busy_b <= pending_next[rd_addr_b];
            end
        end
    end

endmodule
